// File: rtl/stoch_mult_accum_if.sv
// ---------------------------------------------------------------------------
// stoch_mult_accum_if
// Purpose : bundles the stream/control inputs and the product/estimate
//           outputs of stoch_mult_accum into one port.
// Signals : i_en     stream enable (gates product bit and window advance)
//           i_start  one-cycle request to begin or restart a window
//           i_din    N input stochastic bitstreams
//           o_dout   registered product bitstream
//           o_count  ones count of the last completed window (W+1 bits)
//           o_done   one-cycle pulse, o_count valid in that cycle
//           o_busy   high while a window is in progress
// Modports: master drives the inputs (stimulus side), slave is the block.
// ---------------------------------------------------------------------------
interface stoch_mult_accum_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic         i_en;
    logic         i_start;
    logic [N-1:0] i_din;
    logic         o_dout;
    logic [W:0]   o_count;
    logic         o_done;
    logic         o_busy;

    modport master (
        output i_en, i_start, i_din,
        input  o_dout, o_count, o_done, o_busy
    );

    modport slave (
        input  i_en, i_start, i_din,
        output o_dout, o_count, o_done, o_busy
    );
endinterface

// File: rtl/stoch_mult_accum.sv
// ---------------------------------------------------------------------------
// stoch_mult_accum
// Purpose : N-input stochastic multiplier (AND for unipolar, XNOR cascade
//           for bipolar) with a windowed ones counter. Counts product ones
//           over 2^W enabled cycles, then reports the count with a DONE
//           pulse.
// Ports   : i_clk    system clock, rising edge
//           i_rst_n  asynchronous active-low reset
//           io_bus   stoch_mult_accum_if.slave (en, start, din in;
//                    dout, count, done, busy out)
// Params  : N (inputs, >=1), W (log2 window, 1..16), MODE (0 AND, 1 XNOR)
// Macro   : STOCH_MULT_CONT_EN -- continuous mode; DONE goes straight back
//           to RUN and the enabled cycle coincident with DONE is counted
//           as cycle 1 of the next window. Undefined: single-shot.
// ---------------------------------------------------------------------------
// state  | meaning
// S_IDLE | waiting for START, BUSY=0
// S_RUN  | window in progress, counting product ones on enabled cycles
// S_DONE | one cycle, DONE=1, COUNT holds the finished window's total
// ---------------------------------------------------------------------------
module stoch_mult_accum #(
    parameter int N    = 3,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    stoch_mult_accum_if.slave   io_bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Value of the window counter on the last enabled cycle of a window.
    localparam logic [W:0] C_LAST = {1'b0, {W{1'b1}}};

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_out;
    logic [W:0] r_acc;
    logic [W:0] r_wcnt;
    logic [W:0] r_count;

    logic       w_prod;
    logic [W:0] w_prod_ext;
    logic       w_clr;
    logic       w_inc;
    logic       w_load;
    logic [W:0] w_acc_nxt;
    logic [W:0] w_wcnt_nxt;
    logic       w_busy;

    // Product bit: AND chain, or left-to-right XNOR cascade. N=1 passes IN[0].
    always_comb begin
        w_prod = io_bus.i_din[0];
        for (int k = 1; k < N; k++) begin
            if (MODE == 0) begin
                w_prod = w_prod & io_bus.i_din[k];
            end else begin
                w_prod = ~(w_prod ^ io_bus.i_din[k]);
            end
        end
    end

    assign w_prod_ext = {{W{1'b0}}, w_prod};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_start) begin
                    w_state_nxt = S_RUN;
                    w_clr       = 1'b1;
                end
            end
            S_RUN: begin
                if (io_bus.i_start) begin
                    // Restart: this cycle's product bit is discarded.
                    w_clr = 1'b1;
                end else if (io_bus.i_en) begin
                    w_inc = 1'b1;
                    if (r_wcnt == C_LAST) begin
                        w_state_nxt = S_DONE;
                        w_load      = 1'b1;
                    end
                end
            end
            S_DONE: begin
`ifdef STOCH_MULT_CONT_EN
                // Clear and, unless restarting, count this cycle as the
                // first one of the next window so no stream bit is lost.
                w_state_nxt = S_RUN;
                w_clr       = 1'b1;
                w_inc       = io_bus.i_en & ~io_bus.i_start;
`else
                w_state_nxt = io_bus.i_start ? S_RUN : S_IDLE;
                w_clr       = io_bus.i_start;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_acc_nxt  = (w_clr ? '0 : r_acc) + (w_inc ? w_prod_ext : '0);
        w_wcnt_nxt = (w_clr ? '0 : r_wcnt) + {{W{1'b0}}, w_inc};
    end

    // COUNT is loaded on the final enabled cycle so the finished total is
    // already visible while DONE is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out   <= 1'b0;
            r_acc   <= '0;
            r_wcnt  <= '0;
            r_count <= '0;
        end else begin
            r_out  <= io_bus.i_en & w_prod;
            r_acc  <= w_acc_nxt;
            r_wcnt <= w_wcnt_nxt;
            if (w_load) begin
                r_count <= w_acc_nxt;
            end
        end
    end

`ifdef STOCH_MULT_CONT_EN
    assign w_busy = (r_state != S_IDLE);
`else
    assign w_busy = (r_state == S_RUN);
`endif

    assign io_bus.o_dout  = r_out;
    assign io_bus.o_count = r_count;
    assign io_bus.o_done  = (r_state == S_DONE);
    assign io_bus.o_busy  = w_busy;

endmodule

// File: tb/tb_stoch_mult_accum.sv
// ---------------------------------------------------------------------------
// tb_stoch_mult_accum
// Two instances (MODE=0 and MODE=1, N=3, W=4) share one stimulus stream.
// Each window's input vectors are generated up front; the expected ones
// count (AND: all inputs high; bipolar: even number of zero inputs) and the
// cycle at which DONE must appear are pushed to a queue per instance. A
// monitor on the falling edge pops and compares whenever DONE is seen and
// flags a DONE that is missing past its due cycle or arrives unannounced.
// OUT is compared every cycle against EN & product of the previous cycle.
// Cycle bookkeeping: cyc counts rising edges. With START sampled at the
// edge that makes cyc = s, DONE is high in the cycle following edge
// s + 2^W + (disabled cycles), i.e. 2^W+1+gaps cycles after the START cycle.
// ---------------------------------------------------------------------------
module tb_stoch_mult_accum;
    localparam int N   = 3;
    localparam int W   = 4;
    localparam int WIN = 1 << W;

    typedef struct {
        int cnt;
        int at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic e_out0 = 1'b0;
    logic e_out1 = 1'b0;

    always #5 clk = ~clk;

    stoch_mult_accum_if #(.N(N), .W(W)) if0 ();
    stoch_mult_accum_if #(.N(N), .W(W)) if1 ();

    assign if1.i_en    = if0.i_en;
    assign if1.i_start = if0.i_start;
    assign if1.i_din   = if0.i_din;

    stoch_mult_accum #(.N(N), .W(W), .MODE(0)) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (if0.slave)
    );

    stoch_mult_accum #(.N(N), .W(W), .MODE(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (if1.slave)
    );

    function automatic logic prod_uni(input logic [N-1:0] v);
        return &v;
    endfunction

    // Bipolar: a 0 bit encodes -1, so the product is +1 for an even number of zeros.
    function automatic logic prod_bip(input logic [N-1:0] v);
        return ((N - $countones(v)) % 2) == 0;
    endfunction

    function automatic logic [2:0] gen(input int kind, input int i);
        logic [2:0] r;
        logic       b;
        r = 3'($urandom);
        b = 1'($urandom);
        case (kind)
            1: r = 3'b111;
            2: r = {2'b11, ~i[0]};
            3: r = r & 3'b101;
            4: r = {1'b1, b, ~b};
            5: r = {1'b1, b, b};
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s (cyc %0d)", name, what, cyc);
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        e_out0 <= rst_n & if0.i_en & prod_uni(if0.i_din);
        e_out1 <= rst_n & if0.i_en & prod_bip(if0.i_din);
    end

    task automatic mon(input int d, input logic done, input logic [W:0] count, input logic busy);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            if (d == 0) e = q0[0];
            else        e = q1[0];
        end
        if (done) begin
            if (n == 0) begin
                fail($sformatf("done_unexpected[dut%0d]", d), "got DONE, expected none");
            end else begin
                if (d == 0) q0.delete(0);
                else        q1.delete(0);
                check($sformatf("count[dut%0d]", d), 32'(count), e.cnt);
                check($sformatf("done_cycle[dut%0d]", d), cyc, e.at);
                check($sformatf("busy_at_done[dut%0d]", d), 32'(busy), 0);
            end
        end else if (n > 0 && cyc > e.at) begin
            fail($sformatf("done_missing[dut%0d]", d), $sformatf("no DONE, expected at cyc %0d", e.at));
            if (d == 0) q0.delete(0);
            else        q1.delete(0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out[dut0]", 32'(if0.o_dout), 32'(e_out0));
                check("out[dut1]", 32'(if1.o_dout), 32'(e_out1));
                mon(0, if0.o_done, if0.o_count, if0.o_busy);
                mon(1, if1.o_done, if1.o_count, if1.o_busy);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            if0.i_start = 1'b0;
            if0.i_en    = 1'($urandom);
            if0.i_din   = N'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic do_window(input int kind, input int gap_at, input int gap_len);
        logic [N-1:0] vec [WIN];
        int   c0;
        int   c1;
        int   d;
        exp_t e;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < WIN; i++) begin
            vec[i] = gen(kind, i);
            c0 += int'(prod_uni(vec[i]));
            c1 += int'(prod_bip(vec[i]));
        end
        d = (gap_at >= 0 && gap_at < WIN) ? gap_len : 0;
        if0.i_start = 1'b1;
        if0.i_en    = 1'($urandom);
        if0.i_din   = N'($urandom);
        @(negedge clk);
        if0.i_start = 1'b0;
        e.at  = cyc + WIN + d;
        e.cnt = c0;
        q0.push_back(e);
        e.cnt = c1;
        q1.push_back(e);
        check("busy_run[dut0]", 32'(if0.o_busy), 1);
        for (int i = 0; i < WIN; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    if0.i_en  = 1'b0;
                    if0.i_din = N'($urandom);
                    @(negedge clk);
                end
            end
            if0.i_en  = 1'b1;
            if0.i_din = vec[i];
            @(negedge clk);
        end
    endtask

    task automatic do_restart(input int k);
        if0.i_start = 1'b1;
        if0.i_en    = 1'b1;
        if0.i_din   = N'($urandom);
        @(negedge clk);
        if0.i_start = 1'b0;
        repeat (k) begin
            if0.i_en  = 1'b1;
            if0.i_din = N'($urandom);
            @(negedge clk);
        end
        check("busy_before_restart[dut0]", 32'(if0.o_busy), 1);
        do_window(0, -1, 0);
    endtask

    task automatic do_reset_mid(input int k);
        if0.i_start = 1'b1;
        if0.i_en    = 1'b1;
        if0.i_din   = 3'b111;
        @(negedge clk);
        if0.i_start = 1'b0;
        repeat (k) begin
            if0.i_en  = 1'b1;
            if0.i_din = 3'b111;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out[dut0]",   32'(if0.o_dout),  0);
        check("rst_mid_count[dut0]", 32'(if0.o_count), 0);
        check("rst_mid_done[dut0]",  32'(if0.o_done),  0);
        check("rst_mid_busy[dut0]",  32'(if0.o_busy),  0);
        check("rst_mid_count[dut1]", 32'(if1.o_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        if0.i_start = 1'b0;
        if0.i_en    = 1'b0;
        if0.i_din   = '0;
        #3;
        check("rst_out[dut0]",   32'(if0.o_dout),  0);
        check("rst_count[dut0]", 32'(if0.o_count), 0);
        check("rst_done[dut0]",  32'(if0.o_done),  0);
        check("rst_busy[dut0]",  32'(if0.o_busy),  0);
        check("rst_count[dut1]", 32'(if1.o_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        do_window(1, -1, 0);      // all ones: 16 / 16
        idle(3);
        do_window(2, -1, 0);      // IN[0] toggling: AND gives 8
        do_window(3, -1, 0);      // IN[1]=0: AND gives 0
        idle(1);
        do_window(4, -1, 0);      // IN[0]=~IN[1]: bipolar 0
        do_window(5, -1, 0);      // IN[0]=IN[1]: bipolar 16
        idle(2);
        do_window(1, 6, 5);       // five EN-low cycles mid-window
        idle(2);
        do_reset_mid(7);
        idle(2);
        do_restart(10);
        idle(1);

        for (int w = 0; w < 8; w++) begin
            int kind;
            int gap_at;
            int gap_len;
            kind    = int'($urandom_range(0, 5));
            gap_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, WIN - 1)) : -1;
            gap_len = int'($urandom_range(1, 4));
            do_window(kind, gap_at, gap_len);
            idle(int'($urandom_range(0, 3)));
        end

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
            idle(1);
            guard++;
        end
        if (q0.size() != 0) fail("drain[dut0]", "expected DONE never arrived");
        if (q1.size() != 0) fail("drain[dut1]", "expected DONE never arrived");
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
